// File: rtl/mem_read_sched_if.sv
`timescale 1ns/1ps
// mem_read_sched_if
// Bundles the request, memory-read and output-stream signals of the
// read-port scheduler.
//   slave  : scheduler side (consumes requests, drives memory address and stream)
//   master : environment side (requesters, memory model, stream consumer)
interface mem_read_sched_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [7:0]        req0_len;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [7:0]        req1_len;
   logic              req1_ready;
   logic [ADDR_W-1:0] mem_rd_adr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_id;
   logic              out_last;
   logic              done;
   logic              err;
   logic              busy;

   modport slave (
      input  req0_valid, req0_addr, req0_len,
      input  req1_valid, req1_addr, req1_len,
      output req0_ready, req1_ready,
      output mem_rd_adr,
      input  mem_rd_data,
      output out_valid, out_data, out_id, out_last,
      input  out_ready,
      output done, err, busy
   );

   modport master (
      output req0_valid, req0_addr, req0_len,
      output req1_valid, req1_addr, req1_len,
      input  req0_ready, req1_ready,
      input  mem_rd_adr,
      output mem_rd_data,
      input  out_valid, out_data, out_id, out_last,
      output out_ready,
      input  done, err, busy
   );
endinterface

// File: rtl/mem_read_sched.sv
`timescale 1ns/1ps
// mem_read_sched
// Read-port scheduler for the shared memory. Arbitrates burst read requests
// from two requesters (round robin on ties), owns the memory read address and
// streams the words out over a valid/ready channel tagged with requester ID.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_read_sched_if.slave (requests, memory address/data, output
//           stream, done/err/busy status)
module mem_read_sched #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_read_sched_if.slave     bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // One extra bit so MEM_DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        left_q;
   logic              id_q;
   logic              last_grant;
   logic              done_q;
   logic              err_q;

   logic              grant;
   logic              accept;
   logic              beat;
   logic              is_last;
   logic              addr_bad;
   logic              len_zero;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_len;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Arbitration, next state and handshake outputs
   always_comb begin
      state_d        = state_q;
      grant          = 1'b0;
      accept         = 1'b0;
      beat           = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.out_valid  = 1'b0;

      is_last  = (left_q == 8'd1);
      sel_addr = '0;
      sel_len  = '0;
      addr_bad = 1'b0;
      len_zero = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Tie goes to whoever did not win last time.
            if (bus.req0_valid && bus.req1_valid) begin
               grant = ~last_grant;
            end else begin
               grant = bus.req1_valid;
            end
            accept   = bus.req0_valid || bus.req1_valid;
            sel_addr = grant ? bus.req1_addr : bus.req0_addr;
            sel_len  = grant ? bus.req1_len  : bus.req0_len;
            addr_bad = ({1'b0, sel_addr} >= DEPTH_V);
            len_zero = (sel_len == 8'd0);

            bus.req0_ready = accept && !grant;
            bus.req1_ready = accept &&  grant;

            if (accept && !addr_bad && !len_zero) begin
               state_d = BURST;
            end
         end
         BURST: begin
            bus.out_valid = 1'b1;
            beat          = bus.out_ready;
            if (beat && is_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst datapath and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         left_q     <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (accept) begin
            addr_q     <= sel_addr;
            left_q     <= sel_len;
            id_q       <= grant;
            last_grant <= grant;
            done_q     <= addr_bad || len_zero;
            err_q      <= addr_bad;
         end else if (beat) begin
            left_q <= left_q - 8'd1;
            addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            done_q <= is_last;
         end
      end
   end

   assign bus.mem_rd_adr = addr_q;
   assign bus.out_data   = bus.mem_rd_data;
   assign bus.out_id     = id_q;
   assign bus.out_last   = (state_q == BURST) && is_last;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state_q != IDLE);

endmodule
